// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard scan-code decoder.
package ps2_pkg;

  // Prefix-tracking states of the scan-code decoder.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;
  localparam logic [7:0] LSHIFT  = 8'h12;
  localparam logic [7:0] RSHIFT  = 8'h59;
  localparam logic [7:0] CAPS    = 8'h58;

  // One decoded key event as stored in the event FIFO.
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead event FIFO: head entry is visible on dout_o whenever valid_o is high.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  ps2_evt_t                     din_i,
  input  logic                         pop_i,
  output ps2_evt_t                     dout_o,
  output logic                         valid_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  ps2_evt_t      mem_q [DEPTH];
  logic          do_push_s;
  logic          do_pop_s;

  // Accept/commit decisions; a push into a full FIFO is taken only alongside a pop.
  always_comb begin
    valid_o   = (count_q != '0);
    full_o    = (count_q == CW'(DEPTH));
    do_pop_s  = pop_i && valid_o;
    do_push_s = push_i && (!full_o || do_pop_s);
    wr_ptr_d  = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = do_pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(do_push_s) - CW'(do_pop_s);
    if (valid_o) begin
      dout_o = mem_q[rd_ptr_q];
    end else begin
      dout_o = '0;
    end
    count_o = count_q;
  end

  // Pointer and occupancy registers; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: prefix decode, repeat/modifier tracking, event FIFO.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [7:0]                  evt_code,
  output logic                        evt_ext,
  output logic                        evt_break,
  output logic                        evt_repeat,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_count,
  output logic                        overflow,
  input  logic                        clr_ovf,
  output logic                        shift,
  output logic                        caps
);

  ps2_state_t state_q, state_d;
  ps2_evt_t   ev_q, ev_d;
  logic       push_q, push_d;
  logic       lm_valid_q, lm_valid_d;
  logic       lm_ext_q, lm_ext_d;
  logic [7:0] lm_code_q, lm_code_d;
  logic       lshift_q, lshift_d;
  logic       rshift_q, rshift_d;
  logic       caps_q, caps_d;
  logic       ovf_q, ovf_d;
  logic       fire_s;
  logic       lm_hit_s;
  ps2_evt_t   head_s;
  logic       fifo_full_s;
  logic       pop_s;

  // Prefix FSM plus event formation, repeat detection and modifier tracking.
  always_comb begin
    state_d    = state_q;
    fire_s     = 1'b0;
    ev_d       = '0;
    lm_valid_d = lm_valid_q;
    lm_ext_d   = lm_ext_q;
    lm_code_d  = lm_code_q;
    lshift_d   = lshift_q;
    rshift_d   = rshift_q;
    caps_d     = caps_q;
    lm_hit_s   = 1'b0;
    if (rx_valid) begin
      if (rx_data == 8'h00 || rx_data == 8'hFF) begin
        state_d = IDLE;
      end else begin
        ev_d.code = rx_data;
        case (state_q)
          IDLE: begin
            if (rx_data == PFX_EXT)      state_d = EXT;
            else if (rx_data == PFX_BRK) state_d = BRK;
            else                         fire_s  = 1'b1;
          end
          EXT: begin
            ev_d.ext = 1'b1;
            if (rx_data == PFX_BRK)      state_d = EXT_BRK;
            else if (rx_data == PFX_EXT) state_d = EXT;
            else                         fire_s  = 1'b1;
          end
          BRK: begin
            ev_d.brk = 1'b1;
            if (rx_data == PFX_BRK) state_d = BRK;
            else                    fire_s  = 1'b1;
          end
          EXT_BRK: begin
            ev_d.ext = 1'b1;
            ev_d.brk = 1'b1;
            if (rx_data == PFX_BRK) state_d = EXT_BRK;
            else                    fire_s  = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end else begin
      state_d = state_q;
    end

    if (fire_s) begin
      state_d  = IDLE;
      lm_hit_s = lm_valid_q && (lm_ext_q == ev_d.ext) && (lm_code_q == ev_d.code);
      if (ev_d.brk) begin
        if (lm_hit_s) lm_valid_d = 1'b0;
        else          lm_valid_d = lm_valid_q;
      end else if (lm_hit_s) begin
        ev_d.rep = 1'b1;
      end else begin
        lm_valid_d = 1'b1;
        lm_ext_d   = ev_d.ext;
        lm_code_d  = ev_d.code;
      end
      if (!ev_d.ext) begin
        if (ev_d.code == LSHIFT)      lshift_d = !ev_d.brk;
        else if (ev_d.code == RSHIFT) rshift_d = !ev_d.brk;
        else if (ev_d.code == CAPS && !ev_d.brk && !ev_d.rep) caps_d = !caps_q;
        else                          caps_d = caps_q;
      end else begin
        caps_d = caps_q;
      end
    end else begin
      ev_d = '0;
    end
    push_d = fire_s;
  end

  // Sticky drop flag: a rejected push sets it and wins over a same-cycle clear.
  always_comb begin
    pop_s = evt_valid && evt_ready;
    if (push_q && fifo_full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Decoder, modifier and staged-event registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      ev_q       <= '0;
      push_q     <= 1'b0;
      lm_valid_q <= 1'b0;
      lm_ext_q   <= 1'b0;
      lm_code_q  <= 8'h00;
      lshift_q   <= 1'b0;
      rshift_q   <= 1'b0;
      caps_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ev_q       <= ev_d;
      push_q     <= push_d;
      lm_valid_q <= lm_valid_d;
      lm_ext_q   <= lm_ext_d;
      lm_code_q  <= lm_code_d;
      lshift_q   <= lshift_d;
      rshift_q   <= rshift_d;
      caps_q     <= caps_d;
      ovf_q      <= ovf_d;
    end
  end

  ps2_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_q),
    .din_i   (ev_q),
    .pop_i   (evt_ready),
    .dout_o  (head_s),
    .valid_o (evt_valid),
    .full_o  (fifo_full_s),
    .count_o (fifo_count)
  );

  // Output mapping from the FIFO head and tracked state.
  always_comb begin
    evt_code   = head_s.code;
    evt_ext    = head_s.ext;
    evt_break  = head_s.brk;
    evt_repeat = head_s.rep;
    overflow   = ovf_q;
    shift      = lshift_q | rshift_q;
    caps       = caps_q;
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed self-checking bench for ps2_kbd_ctrl (DEPTH=4).
module tb_ps2_kbd_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [7:0] evt_code;
  logic       evt_ext, evt_break, evt_repeat;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  logic       overflow;
  logic       clr_ovf = 1'b0;
  logic       shift, caps;

  int n_checks = 0;
  int n_err = 0;

  ps2_kbd_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_break(evt_break), .evt_repeat(evt_repeat),
    .fifo_count(fifo_count), .overflow(overflow), .clr_ovf(clr_ovf),
    .shift(shift), .caps(caps)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pop();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [7:0] code, input logic e, input logic b, input logic r);
    chk(tag, {21'd0, evt_valid, evt_code, evt_ext, evt_break, evt_repeat},
        {21'd0, 1'b1, code, e, b, r});
  endtask

  logic [7:0] codes [6];

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_mods", {30'd0, shift, caps}, 32'd0);
    chk("rst_head", {21'd0, evt_code, evt_ext, evt_break, evt_repeat}, 32'd0);
    reset = 1'b1;
    tick();

    // Make then break of 1C, latency two cycles after final byte
    evt_ready = 1'b1;
    send(8'h1C);
    chk("lat_make_early", 32'(evt_valid), 32'd0);
    tick();
    chk_head("make_1c", 8'h1C, 1'b0, 1'b0, 1'b0);
    send(8'hF0);
    send(8'h1C);
    chk("lat_brk_early", 32'(evt_valid), 32'd0);
    tick();
    chk_head("brk_1c", 8'h1C, 1'b0, 1'b1, 1'b0);
    tick();
    evt_ready = 1'b0;

    // Extended make, typematic repeat, extended break
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    tick();
    chk("ext_count", 32'(fifo_count), 32'd3);
    chk_head("ext_make", 8'h75, 1'b1, 1'b0, 1'b0);
    tick();
    chk_head("ext_stall_stable", 8'h75, 1'b1, 1'b0, 1'b0);
    pop();
    chk_head("ext_repeat", 8'h75, 1'b1, 1'b0, 1'b1);
    pop();
    chk_head("ext_break", 8'h75, 1'b1, 1'b1, 1'b0);
    pop();
    chk("ext_drained", 32'(evt_valid), 32'd0);

    // Overflow with DEPTH+2 makes; set beats a same-cycle clear
    codes[0] = 8'h15; codes[1] = 8'h1D; codes[2] = 8'h24;
    codes[3] = 8'h2D; codes[4] = 8'h2C; codes[5] = 8'h35;
    for (int i = 0; i < 6; i++) send(codes[i]);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(fifo_count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      chk_head($sformatf("ovf_order%0d", i), codes[i], 1'b0, 1'b0, 1'b0);
      pop();
    end
    chk("ovf_empty", 32'(fifo_count), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO: push and pop in the same cycle
    codes[0] = 8'h1C; codes[1] = 8'h1B; codes[2] = 8'h23; codes[3] = 8'h2B; codes[4] = 8'h34;
    for (int i = 0; i < 4; i++) send(codes[i]);
    tick();
    chk("full_count", 32'(fifo_count), 32'(DEPTH));
    send(codes[4]);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("pp_count", 32'(fifo_count), 32'(DEPTH));
    chk("pp_no_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 5; i++) begin
      chk_head($sformatf("pp_order%0d", i), codes[i], 1'b0, 1'b0, 1'b0);
      pop();
    end

    // Shift and caps tracking
    evt_ready = 1'b1;
    send(8'h12);
    chk("shift_on", 32'(shift), 32'd1);
    send(8'h58);
    chk("caps_on", 32'(caps), 32'd1);
    send(8'h58);
    chk("caps_rep_hold", 32'(caps), 32'd1);
    send(8'hF0); send(8'h58);
    chk("caps_brk_hold", 32'(caps), 32'd1);
    send(8'h58);
    chk("caps_off", 32'(caps), 32'd0);
    send(8'hF0); send(8'h12);
    chk("shift_off", 32'(shift), 32'd0);
    tick(); tick(); tick();
    evt_ready = 1'b0;
    chk("mods_drained", 32'(fifo_count), 32'd0);

    // Reset between prefix and code byte discards the prefix
    send(8'hE0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    send(8'h1C);
    tick();
    chk("rstpfx_count", 32'(fifo_count), 32'd1);
    chk_head("rstpfx_evt", 8'h1C, 1'b0, 1'b0, 1'b0);
    pop();

    // 00 mid-sequence drops the break prefix; 1C still matches last make
    send(8'hF0); send(8'h00); send(8'h1C);
    tick();
    chk("zero_count", 32'(fifo_count), 32'd1);
    chk_head("zero_evt", 8'h1C, 1'b0, 1'b0, 1'b1);
    pop();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
